// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one Wishbone B4 pipelined slave among N masters.
// Optional bus watchdog enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADR_W     = 16,
    parameter int DAT_W     = 32,
    parameter int SEL_W     = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic [N_MASTERS-1:0]       m_cyc_i,
    input  logic [N_MASTERS-1:0]       m_stb_i,
    input  logic [N_MASTERS-1:0]       m_we_i,
    input  logic [N_MASTERS*SEL_W-1:0] m_sel_i,
    input  logic [N_MASTERS*ADR_W-1:0] m_adr_i,
    input  logic [N_MASTERS*DAT_W-1:0] m_dat_i,
    output logic [DAT_W-1:0]           m_dat_o,
    output logic [N_MASTERS-1:0]       m_stall_o,
    output logic [N_MASTERS-1:0]       m_ack_o,
    output logic [N_MASTERS-1:0]       m_err_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic                       s_we_o,
    output logic [SEL_W-1:0]           s_sel_o,
    output logic [ADR_W-1:0]           s_adr_o,
    output logic [DAT_W-1:0]           s_dat_o,
    input  logic [DAT_W-1:0]           s_dat_i,
    input  logic                       s_stall_i,
    input  logic                       s_ack_i,
    output logic [N_MASTERS-1:0]       grant_o
);
    localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

`ifdef WB_ARBITER_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, OWNED, RELEASE} state_t;
`else
    typedef enum logic [1:0] {IDLE, OWNED} state_t;
`endif

    state_t        state, state_d;
    logic [OW-1:0] owner, owner_d, pick, scan, msel;
    logic          any, live, to;

    // owner keeps its value through IDLE, so it also serves as the round-robin pointer
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            state <= IDLE;
            owner <= OW'(N_MASTERS - 1);
        end else begin
            state <= state_d;
            owner <= owner_d;
        end

    always_comb begin
        pick = '0;
        any  = 1'b0;
        scan = '0;
        for (int i = N_MASTERS; i >= 1; i--) begin
            scan = OW'((int'(owner) + i) % N_MASTERS);
            if (m_cyc_i[scan]) begin
                pick = scan;
                any  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        owner_d = owner;
        case (state)
            IDLE: if (any) begin
                state_d = OWNED;
                owner_d = pick;
            end
`ifdef WB_ARBITER_TIMEOUT_EN
            OWNED:   state_d = !m_cyc_i[owner] ? IDLE : (to ? RELEASE : OWNED);
            RELEASE: state_d = m_cyc_i[owner] ? RELEASE : IDLE;
`else
            OWNED:   state_d = m_cyc_i[owner] ? OWNED : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd;
    logic          act;

    assign act = s_ack_i | (m_stb_i[owner] & ~s_stall_i);
    assign to  = (state == OWNED) && m_cyc_i[owner] && !act && (wd == CW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni)
            wd <= '0;
        else if (state != OWNED || act)
            wd <= '0;
        else if (m_cyc_i[owner])
            wd <= wd + 1'b1;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign to = 1'b0;
`endif

    assign live    = (state == OWNED) && !to;
    assign s_cyc_o = live & m_cyc_i[owner];
    assign s_stb_o = live & m_stb_i[owner];
    assign msel    = s_cyc_o ? owner : '0;
    assign s_we_o  = m_we_i[msel];
    assign s_sel_o = m_sel_i[int'(msel)*SEL_W +: SEL_W];
    assign s_adr_o = m_adr_i[int'(msel)*ADR_W +: ADR_W];
    assign s_dat_o = m_dat_i[int'(msel)*DAT_W +: DAT_W];
    assign m_dat_o = s_dat_i;

    always_comb begin
        grant_o   = '0;
        m_stall_o = '1;
        m_ack_o   = '0;
        m_err_o   = '0;
        if (state != IDLE)
            grant_o[owner] = 1'b1;
        if (live) begin
            m_stall_o[owner] = s_stall_i;
            m_ack_o[owner]   = s_ack_i;
        end
        m_err_o[owner] = to;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard-driven checks of grant order, muxing, pipelining, reset and watchdog.
module tb_wb_arbiter;
    localparam int N = 2, AW = 16, DW = 32, SW = 4;
`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    typedef struct packed {
        logic [N-1:0]  m;
        logic [DW-1:0] d;
    } ack_t;

    logic wb_clk_i = 1'b0;
    logic wb_rst_ni = 1'b0;
    logic [N-1:0]    m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
    logic [N*SW-1:0] m_sel_i = '0;
    logic [N*AW-1:0] m_adr_i = '0;
    logic [N*DW-1:0] m_dat_i = '0;
    logic [DW-1:0]   m_dat_o, s_dat_o;
    logic [DW-1:0]   s_dat_i = '0;
    logic [N-1:0]    m_stall_o, m_ack_o, m_err_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [SW-1:0]   s_sel_o;
    logic [AW-1:0]   s_adr_o;
    logic            s_stall_i = 1'b0, s_ack_i = 1'b0;

    int total = 0, bad = 0;
    ack_t ack_q [$];

    wb_arbiter #(.N_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .SEL_W(SW), .TIMEOUT(TO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_stall_o(m_stall_o),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_stall_i(s_stall_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic step;
        @(posedge wb_clk_i);
        #1;
    endtask

    function automatic logic [DW-1:0] rdat(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    task automatic test_reset;
        wb_rst_ni = 1'b0; m_cyc_i = 2'b11; s_ack_i = 1'b1;
        step; step;
        #1;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", grant_o); end
        total++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin bad++; $display("FAIL reset_cyc got=%b%b want=00", s_cyc_o, s_stb_o); end
        total++; if (m_stall_o !== 2'b11) begin bad++; $display("FAIL reset_stall got=%b want=11", m_stall_o); end
        total++; if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin bad++; $display("FAIL reset_ack_err got=%b/%b want=00/00", m_ack_o, m_err_o); end
        s_ack_i = 1'b0;
        step;
        wb_rst_ni = 1'b1;
        #1;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL release_grant got=%b want=00", grant_o); end
        step;
        total++; if (grant_o !== 2'b01 || s_cyc_o !== 1'b1) begin bad++; $display("FAIL first_grant got=%b cyc=%b want=01 cyc=1", grant_o, s_cyc_o); end
        m_cyc_i = 2'b00;
        step;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL drop_grant got=%b want=00", grant_o); end
        s_ack_i = 1'b1;
        #1;
        total++; if (m_ack_o !== 2'b00) begin bad++; $display("FAIL idle_ack got=%b want=00", m_ack_o); end
        s_ack_i = 1'b0;
        step;
    endtask

    task automatic test_single_read;
        ack_t e;
        m_adr_i = {16'h0042, 16'h1111}; m_we_i = 2'b00;
        m_cyc_i = 2'b10; m_stb_i = 2'b10;
        #1;
        total++; if (s_stb_o !== 1'b0 || m_stall_o !== 2'b11) begin bad++; $display("FAIL pre_grant got=stb%b stall%b want=stb0 stall11", s_stb_o, m_stall_o); end
        total++; if (s_adr_o !== 16'h1111) begin bad++; $display("FAIL idle_mux got=%h want=1111", s_adr_o); end
        step;
        total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL m1_grant got=%b want=10", grant_o); end
        total++; if (s_adr_o !== 16'h0042 || s_stb_o !== 1'b1 || s_we_o !== 1'b0) begin bad++; $display("FAIL m1_req got=%h/%b/%b want=0042/1/0", s_adr_o, s_stb_o, s_we_o); end
        total++; if (m_stall_o !== 2'b01) begin bad++; $display("FAIL m1_stall got=%b want=01", m_stall_o); end
        ack_q.push_back(ack_t'({2'b10, 32'hDEADBEEF}));
        step;
        m_stb_i = 2'b00; s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
        #1;
        total++;
        if (ack_q.size() == 0) begin bad++; $display("FAIL m1_ack got=%b want=none", m_ack_o); end
        else begin
            e = ack_q.pop_front();
            if (m_ack_o !== e.m || m_dat_o !== e.d) begin bad++; $display("FAIL m1_ack got=%b/%h want=%b/%h", m_ack_o, m_dat_o, e.m, e.d); end
        end
        step;
        s_ack_i = 1'b0; m_cyc_i = 2'b00;
        step;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL m1_release got=%b want=00", grant_o); end
    endtask

    task automatic test_contention;
        int left [N];
        int ph [N];
        logic [N-1:0] prev;
        logic [N-1:0] eg [$];
        logic an;
        logic [DW-1:0] ad;
        ack_t e;
        for (int i = 0; i < 3; i++) begin eg.push_back(2'b01); eg.push_back(2'b10); end
        left = '{3, 3}; ph = '{0, 0}; prev = '0; an = 1'b0; ad = '0; s_stall_i = 1'b0;
        for (int c = 0; c < 150 && (left[0] + left[1]) > 0; c++) begin
            for (int i = 0; i < N; i++) begin
                m_cyc_i[i] = left[i] > 0 && ph[i] != 2;
                m_stb_i[i] = left[i] > 0 && ph[i] == 0;
                m_adr_i[i*AW +: AW] = AW'(i*256 + 3 - left[i]);
            end
            s_ack_i = an; s_dat_i = ad;
            #1;
            total++; if (s_stb_o !== |(m_stb_i & grant_o)) begin bad++; $display("FAIL stb_leak got=%b want=%b", s_stb_o, |(m_stb_i & grant_o)); end
            if (grant_o !== prev) begin
                if (grant_o !== '0) begin
                    total++; if (prev !== '0) begin bad++; $display("FAIL owner_gap got=%b->%b want=idle between", prev, grant_o); end
                    total++;
                    if (eg.size() == 0) begin bad++; $display("FAIL rr_order got=%b want=none", grant_o); end
                    else if (grant_o !== eg.pop_front()) begin bad++; $display("FAIL rr_order got=%b want=other", grant_o); end
                end
                prev = grant_o;
            end
            total++;
            if (s_ack_i) begin
                if (ack_q.size() == 0) begin bad++; $display("FAIL rr_ack got=%b want=none", m_ack_o); end
                else begin
                    e = ack_q.pop_front();
                    if (m_ack_o !== e.m || m_dat_o !== e.d) begin bad++; $display("FAIL rr_ack got=%b/%h want=%b/%h", m_ack_o, m_dat_o, e.m, e.d); end
                end
            end else if (m_ack_o !== '0) begin bad++; $display("FAIL rr_noack got=%b want=00", m_ack_o); end
            an = 1'b0;
            if (s_stb_o && !s_stall_i) begin an = 1'b1; ad = rdat(s_adr_o); end
            for (int i = 0; i < N; i++) begin
                if (ph[i] == 2) ph[i] = 0;
                else if (ph[i] == 0 && m_stb_i[i] && !m_stall_o[i]) begin
                    ph[i] = 1;
                    ack_q.push_back(ack_t'({N'(1) << i, rdat(m_adr_i[i*AW +: AW])}));
                end else if (ph[i] == 1 && m_ack_o[i]) begin
                    ph[i] = 2;
                    left[i]--;
                end
            end
            step;
        end
        total++; if ((left[0] + left[1]) != 0 || eg.size() != 0) begin bad++; $display("FAIL rr_done got=left%0d grants%0d want=left0 grants0", left[0] + left[1], eg.size()); end
        m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
        step; step;
    endtask

    task automatic test_pipeline;
        logic [AW-1:0] aq [$];
        logic [AW-1:0] a, x;
        int n_acc, n_ack, n_push;
        logic stalled, an, seen;
        logic [DW-1:0] ad;
        ack_t e;
        n_acc = 0; n_ack = 0; n_push = 0; stalled = 1'b0; an = 1'b0; seen = 1'b0; ad = '0;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            a = AW'(16'h2000 + n_acc*4);
            m_cyc_i = 2'b01; m_stb_i = {1'b0, n_acc < 4};
            m_adr_i[AW-1:0] = a;
            if (n_push == n_acc && n_acc < 4) begin aq.push_back(a); n_push++; end
            s_stall_i = (n_acc == 1 && !stalled);
            s_ack_i = an; s_dat_i = ad;
            #1;
            if (grant_o === 2'b01) seen = 1'b1;
            if (seen) begin total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL pipe_hold got=%b want=01", grant_o); end end
            if (s_ack_i) begin
                total++;
                if (ack_q.size() == 0) begin bad++; $display("FAIL pipe_ack got=%b want=none", m_ack_o); end
                else begin
                    e = ack_q.pop_front();
                    if (m_ack_o !== e.m || m_dat_o !== e.d) begin bad++; $display("FAIL pipe_ack got=%b/%h want=%b/%h", m_ack_o, m_dat_o, e.m, e.d); end
                end
                n_ack++;
            end
            an = 1'b0;
            if (s_stb_o && s_stall_i) begin
                stalled = 1'b1;
                total++; if (m_stall_o !== 2'b11) begin bad++; $display("FAIL pipe_stall got=%b want=11", m_stall_o); end
            end
            if (s_stb_o && !s_stall_i) begin
                total++;
                if (aq.size() == 0) begin bad++; $display("FAIL pipe_adr got=%h want=none", s_adr_o); end
                else begin
                    x = aq.pop_front();
                    if (s_adr_o !== x) begin bad++; $display("FAIL pipe_adr got=%h want=%h", s_adr_o, x); end
                    ack_q.push_back(ack_t'({2'b01, rdat(x)}));
                end
                n_acc++; an = 1'b1; ad = rdat(s_adr_o);
            end
            step;
        end
        total++; if (n_acc != 4 || n_ack != 4) begin bad++; $display("FAIL pipe_count got=%0d/%0d want=4/4", n_acc, n_ack); end
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL pipe_held got=%b want=01", grant_o); end
        m_cyc_i = 2'b00; m_stb_i = 2'b00; s_ack_i = 1'b0; s_stall_i = 1'b0;
        #1;
        total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL pipe_cyc_drop got=%b want=0", s_cyc_o); end
        step;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL pipe_release got=%b want=00", grant_o); end
    endtask

    task automatic test_async_reset;
        m_cyc_i = 2'b01;
        step;
        total++; if (grant_o !== 2'b01 || s_cyc_o !== 1'b1) begin bad++; $display("FAIL ar_grant got=%b/%b want=01/1", grant_o, s_cyc_o); end
        m_cyc_i = 2'b11;
        #2;
        wb_rst_ni = 1'b0;
        #1;
        total++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b00 || m_stall_o !== 2'b11) begin bad++; $display("FAIL ar_immediate got=%b/%b/%b want=0/00/11", s_cyc_o, grant_o, m_stall_o); end
        step;
        wb_rst_ni = 1'b1;
        step;
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL ar_priority got=%b want=01", grant_o); end
        m_cyc_i = 2'b00;
        step; step;
    endtask

    task automatic test_timeout;
        logic acc, got;
        int k;
        s_stall_i = 1'b0; s_ack_i = 1'b0;
        m_cyc_i = 2'b10; m_stb_i = 2'b10; m_adr_i[AW +: AW] = 16'h0077;
        acc = 1'b0;
        for (int c = 0; c < 10 && !acc; c++) begin
            #1;
            acc = s_stb_o && !s_stall_i;
            step;
        end
        m_stb_i = 2'b00;
        total++; if (!acc) begin bad++; $display("FAIL to_accept got=0 want=1"); end
`ifdef WB_ARBITER_TIMEOUT_EN
        got = 1'b0; k = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            #1;
            if (m_err_o !== 2'b00) begin
                got = 1'b1; k = c;
                total++; if (m_err_o !== 2'b10 || s_cyc_o !== 1'b0) begin bad++; $display("FAIL to_err got=%b/%b want=10/0", m_err_o, s_cyc_o); end
            end else step;
        end
        total++; if (k != 8) begin bad++; $display("FAIL to_latency got=%0d want=8", k); end
        m_cyc_i = 2'b11; s_ack_i = 1'b1;
        step;
        total++; if (m_err_o !== 2'b00 || grant_o !== 2'b10) begin bad++; $display("FAIL to_release got=%b/%b want=00/10", m_err_o, grant_o); end
        total++; if (s_cyc_o !== 1'b0 || m_stall_o !== 2'b11 || m_ack_o !== 2'b00) begin bad++; $display("FAIL to_blocked got=%b/%b/%b want=0/11/00", s_cyc_o, m_stall_o, m_ack_o); end
        s_ack_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step;
            total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL to_hold got=%b want=10", grant_o); end
        end
        m_cyc_i = 2'b01;
        step;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL to_idle got=%b want=00", grant_o); end
        step;
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL to_next got=%b want=01", grant_o); end
`else
        got = 1'b0; k = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_err_o !== 2'b00 || grant_o !== 2'b10) begin got = 1'b1; k = c; end
            step;
        end
        total++; if (got) begin bad++; $display("FAIL no_watchdog got=err%b grant%b at %0d want=err00 grant10", m_err_o, grant_o, k); end
`endif
        m_cyc_i = 2'b00;
        step; step;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_contention;
        test_pipeline;
        test_async_reset;
        test_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Round-robin arbiter that shares one Wishbone B4 pipelined slave port between N masters. Typical masters are the SPI-controlled bus master and on-chip DMA/CPU masters. A grant is held for a master's whole bus cycle (CYC high), so transaction sequences are never interleaved. The block sits between the masters and the peripheral interconnect/decoder.

Parameters:
N_MASTERS, 2, number of masters (2..8)
ADR_W, 16, address width
DAT_W, 32, data width
SEL_W, 4, byte-select width (DAT_W/8)
TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
wb_clk_i  in  1  single clock for all logic
wb_rst_ni  in  1  asynchronous reset, active low
m_cyc_i  in  N_MASTERS  per-master CYC
m_stb_i  in  N_MASTERS  per-master STB
m_we_i  in  N_MASTERS  per-master WE
m_sel_i  in  N_MASTERS*SEL_W  packed SEL; master i at [i*SEL_W +: SEL_W]
m_adr_i  in  N_MASTERS*ADR_W  packed ADR, same packing
m_dat_i  in  N_MASTERS*DAT_W  packed write data, same packing
m_dat_o  out  DAT_W  read data broadcast to all masters (= s_dat_i)
m_stall_o  out  N_MASTERS  per-master STALL
m_ack_o  out  N_MASTERS  per-master ACK
m_err_o  out  N_MASTERS  per-master ERR (watchdog only)
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side CYC/STB/WE
s_sel_o  out  SEL_W  slave-side SEL
s_adr_o  out  ADR_W  slave-side ADR
s_dat_o  out  DAT_W  slave-side write data
s_dat_i  in  DAT_W  slave read data
s_stall_i, s_ack_i  in  1 each  slave STALL/ACK
grant_o  out  N_MASTERS  one-hot current owner; all zero when idle

Behaviour:
- Reset is asynchronous and active low. While wb_rst_ni=0, and immediately on its assertion:
  - state=IDLE, grant_o=0, s_cyc_o=0, s_stb_o=0.
  - m_ack_o=0, m_err_o=0, m_stall_o all 1.
  - last_owner=N_MASTERS-1, so master 0 has first priority after reset.
- State machine: IDLE -> OWNED -> (RELEASE) -> IDLE.
- IDLE:
  - If any m_cyc_i is set, pick the first requester scanning last_owner+1, last_owner+2, ... modulo N_MASTERS.
  - On the next edge, register owner, grant_o and last_owner, then enter OWNED. Arbitration latency is 1 cycle.
  - No requesters: stay in IDLE.
- OWNED (owner k):
  - s_cyc_o=m_cyc_i[k] and s_stb_o=m_stb_i[k]. s_we_o/s_sel_o/s_adr_o/s_dat_o are combinational muxes of master k.
  - m_stall_o[k]=s_stall_i and m_ack_o[k]=s_ack_i.
  - Every non-owner j: m_stall_o[j]=1, m_ack_o[j]=0.
  - When m_cyc_i[k]=0 at an edge: go to IDLE and clear grant_o.
  - One-cycle minimum gap between owners: the slave sees CYC low for at least 1 cycle between masters.
- The owner keeps CYC high until all of its ACKs have returned. The arbiter does not count outstanding requests.
- s_ack_i seen in IDLE is dropped and goes to no master.
- Simultaneous new requests: round-robin order decides. A master that drops and re-raises CYC cannot win twice in a row while others are waiting.
- A non-owner that raises STB only sees STALL; it must hold STB until granted.
- m_dat_o is the raw broadcast of s_dat_i. Masters qualify it with their own ACK.
- Mux-select outputs are don't-care while s_cyc_o=0 but must not contain X. Drive master 0's values.

Optional Feature:
- Macro: WB_ARBITER_TIMEOUT_EN.
- When defined, a watchdog counter:
  - Clears on grant, on every s_ack_i, and on every accepted STB (s_stb_o & !s_stall_i).
  - Otherwise increments while OWNED with CYC high.
- When it reaches TIMEOUT:
  - m_err_o[k] pulses for 1 cycle.
  - s_cyc_o and s_stb_o are forced 0.
  - State enters RELEASE, holding owner with m_stall_o[k]=1 and m_ack_o[k]=0, until m_cyc_i[k]=0, then goes to IDLE.
- When not defined: no counter, no RELEASE state, m_err_o tied to 0.

Test Plan:
- Reset: hold wb_rst_ni=0, drive m_cyc_i=2'b11 -> grant_o=0, s_cyc_o=0, m_stall_o=2'b11. Release reset -> grant_o=2'b01 one cycle later.
- Single read, master 1 only, adr 0x0042: s_adr_o=0x0042 on the cycle after grant. Slave ack with s_dat_i=0xDEADBEEF -> m_ack_o=2'b10, m_dat_o=0xDEADBEEF. No ack to master 0.
- Contention: both masters hold CYC for 3 transactions each -> grants alternate 0,1,0,1 with at least 1 IDLE cycle between them. A non-owner STB never reaches s_stb_o.
- Pipelining: owner issues 4 STBs with s_stall_i high on the 2nd -> exactly 4 accepted STBs at the slave, 4 ACKs forwarded in order. Grant is held until CYC drops.
- Async reset mid-cycle: assert wb_rst_ni=0 between edges during OWNED -> s_cyc_o=0 immediately, before the next edge. After release, master 0 has priority.
- With WB_ARBITER_TIMEOUT_EN and TIMEOUT=8: slave never acks -> m_err_o pulses 8 cycles after the last STB acceptance, s_cyc_o drops, and the grant moves on only after the owner drops CYC.
